// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: tick-driven PWM with period_start pulse and wrap-aligned duty updates.
// Define PWM_DEADTIME_EN to enable the complementary output with DEAD_CYC dead-time.
module pwm_tick_gen #(
    parameter int NBits    = 8,
    parameter int DEAD_CYC = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             tick,
    input  logic [NBits-1:0] period,
    input  logic [NBits-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm,
    output logic             pwm_n,
    output logic             period_start
);
    logic [NBits-1:0] cnt, per_act, duty_act, shadow;
    logic pending, raw, wrap, accept;
    if (DEAD_CYC < 0) begin : g_bad_dead
        $error("DEAD_CYC must be non-negative");
    end
    assign raw    = en && (cnt < duty_act);
    assign wrap   = en && tick && (cnt == per_act);
    assign accept = duty_valid && duty_ready;
    // An accept coinciding with a wrap lands in shadow and waits for the next wrap.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt          <= '0;
            per_act      <= '0;
            duty_act     <= '0;
            shadow       <= '0;
            pending      <= 1'b0;
            duty_ready   <= 1'b0;
            period_start <= 1'b0;
        end else begin
            if (!en) cnt <= '0;
            else if (tick) cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                per_act <= period;
                if (pending) duty_act <= shadow;
            end
            if (accept) shadow <= duty_in;
            pending      <= accept || (pending && !wrap);
            duty_ready   <= !accept && !pending;
            period_start <= wrap;
        end
    end
`ifdef PWM_DEADTIME_EN
    localparam int DW = $clog2(DEAD_CYC + 2);
    logic          raw_q;
    logic [DW-1:0] dt, dt_nxt;
    assign dt_nxt = (raw != raw_q) ? DW'(DEAD_CYC) : ((dt != '0) ? dt - 1'b1 : '0);
    always_ff @(posedge clk) begin
        if (!rstn) begin
            raw_q <= 1'b0;
            dt    <= '0;
            pwm   <= 1'b0;
            pwm_n <= 1'b0;
        end else begin
            raw_q <= raw;
            dt    <= dt_nxt;
            pwm   <= raw && (dt_nxt == '0);
            pwm_n <= en && !raw && (dt_nxt == '0);
        end
    end
`else
    always_ff @(posedge clk) pwm <= rstn && raw;
    assign pwm_n = 1'b0;
`endif
endmodule

// File: tb/tb_pwm_tick_gen.sv
// tb_pwm_tick_gen: randomized and directed checks of pwm_tick_gen against a period/queue model.
module tb_pwm_tick_gen;
    logic       clk = 1'b0;
    logic       rstn = 1'b0, en = 1'b0, tick = 1'b0, duty_valid = 1'b0;
    logic [7:0] period = '0, duty_in = '0;
    logic       duty_ready, pwm, pwm_n, period_start;
    int         errors = 0, checks = 0;

    pwm_tick_gen #(.NBits(8), .DEAD_CYC(2)) dut (
        .clk(clk), .rstn(rstn), .en(en), .tick(tick), .period(period),
        .duty_in(duty_in), .duty_valid(duty_valid), .duty_ready(duty_ready),
        .pwm(pwm), .pwm_n(pwm_n), .period_start(period_start)
    );

    always #5 clk = ~clk;

`ifdef PWM_DEADTIME_EN
    localparam int DEAD = 2;
    localparam int EXP_HI = 1;
`else
    localparam int DEAD = 0;
    localparam int EXP_HI = 3;
`endif

    // Model: position within the current period, period length, active duty, queued duty.
    int  m_pos, m_len, m_duty, m_since;
    int  q[$];
    bit  m_ready, m_pwm, m_pwmn, m_ps, m_rawp;

    task automatic step(input bit r, e, t, dv, input int p, d);
        bit pend, acc, raw;
        @(negedge clk);
        rstn = r; en = e; tick = t; duty_valid = dv; period = 8'(p); duty_in = 8'(d);
        @(posedge clk);
        if (!r) begin
            m_pos = 0; m_len = 1; m_duty = 0; q.delete();
            m_ready = 0; m_pwm = 0; m_pwmn = 0; m_ps = 0; m_rawp = 0; m_since = DEAD;
        end else begin
            pend = q.size() != 0;
            acc  = dv && m_ready;
            raw  = e && (m_pos < m_duty);
            if (raw != m_rawp) m_since = 0;
            else if (m_since < DEAD) m_since++;
            m_rawp = raw;
            m_pwm  = raw && m_since >= DEAD;
`ifdef PWM_DEADTIME_EN
            m_pwmn = e && !raw && m_since >= DEAD;
`else
            m_pwmn = 0;
`endif
            m_ps = 0;
            if (!e) m_pos = 0;
            else if (t) begin
                if (m_pos == m_len - 1) begin
                    m_pos = 0;
                    m_len = p + 1;
                    if (q.size() != 0) m_duty = q.pop_front();
                    m_ps = 1;
                end else m_pos++;
            end
            if (acc) q.push_back(d);
            m_ready = !acc && !pend;
        end
        #1;
    endtask

    task automatic test_reset;
        step(0, 1, 1, 0, 9, 0);
        checks++;
        if ({pwm, pwm_n, period_start, duty_ready} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs got=%b exp=0000", {pwm, pwm_n, period_start, duty_ready});
        end
        step(1, 0, 0, 0, 9, 0);
        checks++;
        if (duty_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_release got=%b exp=1", duty_ready);
        end
    endtask

    task automatic test_basic;
        int hi = 0, ps = 0;
        step(1, 1, 1, 1, 9, 3);
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 1, 0, 9, 0);
            checks++;
            if ({pwm, pwm_n, period_start, duty_ready} !== {m_pwm, m_pwmn, m_ps, m_ready}) begin
                errors++; $display("FAIL basic cyc=%0d got=%b exp=%b", i, {pwm, pwm_n, period_start, duty_ready}, {m_pwm, m_pwmn, m_ps, m_ready});
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 1, 0, 9, 0);
            hi += int'(pwm); ps += int'(period_start);
            if (pwm && pwm_n) begin errors++; $display("FAIL basic_overlap cyc=%0d", i); end
        end
        checks += 2;
        if (hi != EXP_HI) begin errors++; $display("FAIL basic_high_count got=%0d exp=%0d", hi, EXP_HI); end
        if (ps != 1) begin errors++; $display("FAIL basic_period_start_count got=%0d exp=1", ps); end
    endtask

    task automatic test_duty_extremes;
        int vals[2] = '{0, 10};
        foreach (vals[k]) begin
            int hi = 0;
            while (!duty_ready) step(1, 1, 1, 0, 9, 0);
            step(1, 1, 1, 1, 9, vals[k]);
            for (int i = 0; i < 25; i++) begin
                step(1, 1, 1, 0, 9, 0);
                checks++;
                if ({pwm, pwm_n, period_start, duty_ready} !== {m_pwm, m_pwmn, m_ps, m_ready}) begin
                    errors++; $display("FAIL extremes d=%0d cyc=%0d got=%b exp=%b", vals[k], i, {pwm, pwm_n, period_start, duty_ready}, {m_pwm, m_pwmn, m_ps, m_ready});
                end
            end
            for (int i = 0; i < 10; i++) begin step(1, 1, 1, 0, 9, 0); hi += int'(pwm); end
            checks++;
            if (hi != (vals[k] == 0 ? 0 : 10)) begin
                errors++; $display("FAIL extremes_const d=%0d got=%0d exp=%0d", vals[k], hi, vals[k] == 0 ? 0 : 10);
            end
        end
    endtask

    task automatic test_handshake;
        int waited = 0;
        while (!duty_ready) step(1, 1, 1, 0, 9, 0);
        step(1, 1, 1, 1, 9, 3);
        while (!period_start) step(1, 1, 1, 0, 9, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 9, 0);
        step(1, 1, 1, 1, 9, 6);
        checks++;
        if (duty_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_drop got=%b exp=0", duty_ready); end
        for (int i = 0; i < 30; i++) begin
            step(1, 1, 1, 1, 9, 7);
            if (m_ps) waited = i;
            checks++;
            if ({pwm, pwm_n, period_start, duty_ready} !== {m_pwm, m_pwmn, m_ps, m_ready}) begin
                errors++; $display("FAIL handshake cyc=%0d got=%b exp=%b", i, {pwm, pwm_n, period_start, duty_ready}, {m_pwm, m_pwmn, m_ps, m_ready});
            end
        end
        checks++;
        if (waited == 0) begin errors++; $display("FAIL hs_no_wrap got=0 exp=wrap"); end
    endtask

    task automatic test_slow_tick;
        int ps = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 1, (i % 4) == 0, 0, 3, 0);
            checks++;
            if ({pwm, pwm_n, period_start, duty_ready} !== {m_pwm, m_pwmn, m_ps, m_ready}) begin
                errors++; $display("FAIL slow_tick cyc=%0d got=%b exp=%b", i, {pwm, pwm_n, period_start, duty_ready}, {m_pwm, m_pwmn, m_ps, m_ready});
            end
        end
        for (int i = 0; i < 32; i++) begin step(1, 1, (i % 4) == 0, 0, 3, 0); ps += int'(period_start); end
        checks++;
        if (ps != 2) begin errors++; $display("FAIL slow_tick_ps_count got=%0d exp=2", ps); end
    endtask

    task automatic test_reset_mid;
        while (!duty_ready) step(1, 1, 1, 0, 9, 0);
        step(1, 1, 1, 1, 9, 5);
        step(1, 1, 1, 0, 9, 0);
        step(0, 1, 1, 0, 9, 0);
        checks++;
        if ({pwm, pwm_n, period_start, duty_ready} !== 4'b0000) begin
            errors++; $display("FAIL reset_mid got=%b exp=0000", {pwm, pwm_n, period_start, duty_ready});
        end
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 1, 0, 9, 0);
            checks++;
            if ({pwm, pwm_n, period_start, duty_ready} !== {m_pwm, m_pwmn, m_ps, m_ready}) begin
                errors++; $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", i, {pwm, pwm_n, period_start, duty_ready}, {m_pwm, m_pwmn, m_ps, m_ready});
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 19) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 9));
            checks++;
            if ({pwm, pwm_n, period_start, duty_ready} !== {m_pwm, m_pwmn, m_ps, m_ready}) begin
                errors++; $display("FAIL random cyc=%0d got=%b exp=%b", i, {pwm, pwm_n, period_start, duty_ready}, {m_pwm, m_pwmn, m_ps, m_ready});
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_duty_extremes;
        test_handshake;
        test_slow_tick;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
